// File: rtl/branch_predictor_if.sv
// Fetch-lookup and decode-training signals shared by the branch predictor and its neighbours.
// The fetch/decode side uses the master modport and the predictor uses the slave modport.
interface branch_predictor_if #(
    parameter int PC_WIDTH = 32
);
    logic [PC_WIDTH-1:0] F_PC_i;
    logic [PC_WIDTH-1:0] F_pred_PC_o;
    logic                F_pred_taken_o;
    logic                DD_train_vaild_i;
    logic [PC_WIDTH-1:0] DD_train_PC_i;
    logic                DD_train_taken_i;
    logic [PC_WIDTH-1:0] DD_train_target_i;

    modport master (
        output F_PC_i,
        output DD_train_vaild_i,
        output DD_train_PC_i,
        output DD_train_taken_i,
        output DD_train_target_i,
        input  F_pred_PC_o,
        input  F_pred_taken_o
    );

    modport slave (
        input  F_PC_i,
        input  DD_train_vaild_i,
        input  DD_train_PC_i,
        input  DD_train_taken_i,
        input  DD_train_target_i,
        output F_pred_PC_o,
        output F_pred_taken_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit bimodal counters: combinational next-PC prediction for fetch,
// trained at the clock edge by branches and jals resolved in decode.
module branch_predictor #(
    parameter int PC_WIDTH = 32,
    parameter int IDX_W    = 6,
    parameter int TAG_W    = 8
) (
    input logic             clk,
    input logic             rst,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(32'd4);

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic [ENTRIES-1:0]  valid_r;
    logic [1:0]          ctr_r    [ENTRIES];
    logic [TAG_W-1:0]    tag_r    [ENTRIES];
    logic [PC_WIDTH-1:0] target_r [ENTRIES];

    logic [IDX_W-1:0]    lk_idx_s;
    logic [TAG_W-1:0]    lk_tag_s;
    logic                lk_hit_s;
    logic                pred_taken_s;
    logic [PC_WIDTH-1:0] pred_pc_s;

    logic [IDX_W-1:0]    tr_idx_s;
    logic [TAG_W-1:0]    tr_tag_s;
    logic                tr_hit_s;

    assign lk_idx_s = bp.F_PC_i[IDX_W+1:2];
    assign lk_tag_s = bp.F_PC_i[IDX_W+2 +: TAG_W];
    assign tr_idx_s = bp.DD_train_PC_i[IDX_W+1:2];
    assign tr_tag_s = bp.DD_train_PC_i[IDX_W+2 +: TAG_W];

    // Zero-latency lookup; a same-cycle training write is not bypassed.
    always_comb begin
        lk_hit_s     = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
        pred_taken_s = lk_hit_s && ctr_r[lk_idx_s][1];
        if (pred_taken_s) begin
            pred_pc_s = target_r[lk_idx_s];
        end else begin
            pred_pc_s = bp.F_PC_i + PC_STEP;
        end
    end

    assign bp.F_pred_PC_o    = pred_pc_s;
    assign bp.F_pred_taken_o = pred_taken_s;

    // Training-side tag match against the entry at the resolved instruction's index.
    always_comb begin
        tr_hit_s = valid_r[tr_idx_s] && (tag_r[tr_idx_s] == tr_tag_s);
    end

    // Valid bits and counters: cleared by reset, otherwise trained by decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= 2'b00;
            end
        end else if (bp.DD_train_vaild_i) begin
            if (tr_hit_s) begin
                ctr_r[tr_idx_s] <= bp.DD_train_taken_i ? sat_inc(ctr_r[tr_idx_s])
                                                       : sat_dec(ctr_r[tr_idx_s]);
            end else if (bp.DD_train_taken_i) begin
                // Taken miss allocates, evicting any aliasing entry; not-taken misses never allocate.
                valid_r[tr_idx_s] <= 1'b1;
                ctr_r[tr_idx_s]   <= 2'b10;
            end
        end
    end

    // Tags and targets carry no reset but still drop an update that coincides with reset.
    always_ff @(posedge clk) begin
        if (!rst && bp.DD_train_vaild_i && bp.DD_train_taken_i) begin
            tag_r[tr_idx_s]    <= tr_tag_s;
            target_r[tr_idx_s] <= bp.DD_train_target_i;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: table-driven cycle vectors with a scoreboard queue,
// plus a hand-written reset-during-training sequence.
module tb_branch_predictor;
    typedef struct {
        logic        rst;
        logic        tv;
        logic [31:0] tpc;
        logic        tt;
        logic [31:0] ttg;
        logic [31:0] lpc;
        logic [31:0] epc;
        logic        et;
    } vec_t;

    typedef struct {
        logic [31:0] epc;
        logic        et;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    branch_predictor_if #(.PC_WIDTH(32)) bp ();

    branch_predictor #(.PC_WIDTH(32), .IDX_W(6), .TAG_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp.slave)
    );

    function automatic vec_t mk(input logic r, input logic tv, input logic [31:0] tpc,
                                input logic tt, input logic [31:0] ttg, input logic [31:0] lpc,
                                input logic [31:0] epc, input logic et);
        vec_t v;
        v.rst = r; v.tv = tv; v.tpc = tpc; v.tt = tt; v.ttg = ttg;
        v.lpc = lpc; v.epc = epc; v.et = et;
        return v;
    endfunction

    // Drive one cycle's inputs, queue the expected prediction, check it before the training edge.
    task automatic step(input vec_t v, input int id);
        exp_t e;
        @(posedge clk);
        #1;
        rst                  = v.rst;
        bp.DD_train_vaild_i  = v.tv;
        bp.DD_train_PC_i     = v.tpc;
        bp.DD_train_taken_i  = v.tt;
        bp.DD_train_target_i = v.ttg;
        bp.F_PC_i            = v.lpc;
        sb.push_back('{epc: v.epc, et: v.et, id: id});
        @(negedge clk);
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty vec %0d: got no expected entry, required one", id);
        end else begin
            e = sb.pop_front();
            if (bp.F_pred_PC_o !== e.epc || bp.F_pred_taken_o !== e.et) begin
                n_fail++;
                $display("FAIL vec %0d pc=%h: got pred_pc=%h taken=%b, required pred_pc=%h taken=%b",
                         e.id, bp.F_PC_i, bp.F_pred_PC_o, bp.F_pred_taken_o, e.epc, e.et);
            end
        end
    endtask

    initial begin
        rst                  = 1'b1;
        bp.F_PC_i            = 32'h0000_1000;
        bp.DD_train_vaild_i  = 1'b0;
        bp.DD_train_PC_i     = 32'h0;
        bp.DD_train_taken_i  = 1'b0;
        bp.DD_train_target_i = 32'h0;

        //               rst   tv    train PC      tt    target        lookup PC     exp PC        exp T
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_1000, 32'h0000_1004, 1'b0)); // reset state
        vecs.push_back(mk(1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 32'h0000_1000, 32'h0000_1004, 1'b0)); // alloc, no bypass
        vecs.push_back(mk(1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0,        32'h0000_1000, 32'h0000_2000, 1'b1)); // ctr 10
        vecs.push_back(mk(1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0,        32'h0000_1000, 32'h0000_1004, 1'b0)); // ctr 01
        vecs.push_back(mk(1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 32'h0000_1000, 32'h0000_1004, 1'b0)); // ctr 00
        vecs.push_back(mk(1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 32'h0000_1000, 32'h0000_1004, 1'b0)); // ctr 01
        vecs.push_back(mk(1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000, 1'b1)); // ctr 10
        vecs.push_back(mk(1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2400, 32'h0000_1000, 32'h0000_2000, 1'b1)); // ctr 11, 4th taken
        vecs.push_back(mk(1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0,        32'h0000_1000, 32'h0000_2400, 1'b1)); // saturated 11, new target
        vecs.push_back(mk(1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0,        32'h0000_1000, 32'h0000_2400, 1'b1)); // ctr 10
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_1000, 32'h0000_1004, 1'b0)); // ctr 01
        vecs.push_back(mk(1'b0, 1'b1, 32'h0000_1210, 1'b0, 32'h0000_7000, 32'h0000_1210, 32'h0000_1214, 1'b0)); // NT miss
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_1210, 32'h0000_1214, 1'b0)); // not allocated
        vecs.push_back(mk(1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 32'h0000_1100, 32'h0000_1104, 1'b0)); // alias tag miss
        vecs.push_back(mk(1'b0, 1'b1, 32'h0000_1100, 1'b1, 32'h0000_3000, 32'h0000_1000, 32'h0000_2000, 1'b1)); // pre-evict
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_1000, 32'h0000_1004, 1'b0)); // evicted
        vecs.push_back(mk(1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0,        32'h0000_1100, 32'h0000_3000, 1'b1)); // new owner
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_1100, 32'h0000_3000, 1'b1)); // NT alias kept
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_1102, 32'h0000_3000, 1'b1)); // PC[1:0] ignored

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Reset coinciding with a taken allocation: reset wins, then the wrap boundary.
        step(mk(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0040, 32'h0000_1100, 32'h0000_3000, 1'b1), 100);
        step(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'hFFFF_FFFC, 32'h0000_0000, 1'b0), 101);
        step(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_1100, 32'h0000_1104, 1'b0), 102);
        // Taken hit at the top index still wraps correctly through the stored target.
        step(mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0040, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0), 103);
        step(mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'hFFFF_FFFC, 32'h0000_0040, 1'b1), 104);

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
